// File: rtl/tmds_pkg.sv
// Shared definitions for the TMDS channel encoder.
// Holds the four fixed control tokens sent during blanking, the width and
// type of the running-disparity tally, and the 8-bit popcount helper used
// both by transition minimization and by the DC-balance decision.
package tmds_pkg;

  localparam logic [9:0] CTRL_TOKEN_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_TOKEN_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_TOKEN_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_TOKEN_11 = 10'b1010101011;

  localparam int CNT_W = 5;

  typedef logic signed [CNT_W-1:0] disparity_t;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/tmds_encoder_tm_choice.sv
// Transition-minimization stage of the TMDS encoder (purely combinational).
// Chains the input byte through XOR or XNOR, whichever yields fewer
// transitions, and flags the choice in q_m[8] (1 = XOR, 0 = XNOR).
// Ports:
//   data_in  [7:0]  video byte
//   q_m      [8:0]  transition-minimized word plus XOR/XNOR flag
module tm_choice
  import tmds_pkg::*;
(
  input  logic [7:0] data_in,
  output logic [8:0] q_m
);

  logic [3:0] n1;
  logic       use_xnor;

  assign n1 = popcount8(data_in);
  // Ties (four ones) are broken on bit 0 so the choice is deterministic.
  assign use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !data_in[0]);

  always_comb begin
    logic [8:0] q;
    q    = '0;
    q[0] = data_in[0];
    for (int i = 1; i < 8; i++) begin
      q[i] = use_xnor ? ~(q[i-1] ^ data_in[i]) : (q[i-1] ^ data_in[i]);
    end
    q[8] = ~use_xnor;
    q_m  = q;
  end

endmodule

// File: rtl/tmds_encoder.sv
// TMDS channel encoder for DVI/HDMI: one 8-bit video byte or 2-bit control
// symbol per pixel clock in, one 10-bit DC-balanced symbol out (bit 0 sent
// first). A running-disparity tally steers the optional inversion so the
// line stays DC balanced; blanking emits fixed tokens and clears the tally.
// Ports:
//   clk_in           pixel clock
//   rst_in           asynchronous active-high reset (clears output and tally)
//   data_in    [7:0] video byte, used when ve_in = 1
//   control_in [1:0] {C1,C0}, used when ve_in = 0
//   ve_in            video enable
//   tmds_out   [9:0] registered encoded symbol
// Build option: define TMDS_PIPE_EN to add a register stage after
// transition minimization (latency 2 instead of 1, same symbol sequence).
module tmds_encoder
  import tmds_pkg::*;
(
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic [7:0] data_in,
  input  logic [1:0] control_in,
  input  logic       ve_in,
  output logic [9:0] tmds_out
);

  // Stage A: transition minimization
  logic [8:0] q_m_p0;

  tm_choice u_tm_choice (
    .data_in (data_in),
    .q_m     (q_m_p0)
  );

  logic [8:0] q_m_p1;
  logic       vld_p1;
  logic [1:0] ctrl_p1;

`ifdef TMDS_PIPE_EN
  // Stage 1 register: ve resets low so the first symbol is the 00 token
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      q_m_p1  <= '0;
      vld_p1  <= 1'b0;
      ctrl_p1 <= '0;
    end else begin
      q_m_p1  <= q_m_p0;
      vld_p1  <= ve_in;
      ctrl_p1 <= control_in;
    end
  end
`else
  assign q_m_p1  = q_m_p0;
  assign vld_p1  = ve_in;
  assign ctrl_p1 = control_in;
`endif

  // Stage B: DC-balance decision and output register
  disparity_t cnt;
  disparity_t cnt_nxt;
  disparity_t diff_p1;   // N1 - N0 of q_m[7:0]
  logic [3:0] n1_p1;
  logic [3:0] n0_p1;
  logic [9:0] sym_p1;

  assign n1_p1   = popcount8(q_m_p1[7:0]);
  assign n0_p1   = 4'd8 - n1_p1;
  assign diff_p1 = $signed({1'b0, n1_p1}) - $signed({1'b0, n0_p1});

  always_comb begin
    sym_p1  = '0;
    cnt_nxt = cnt;
    if (!vld_p1) begin
      unique case (ctrl_p1)
        2'b00:   sym_p1 = CTRL_TOKEN_00;
        2'b01:   sym_p1 = CTRL_TOKEN_01;
        2'b10:   sym_p1 = CTRL_TOKEN_10;
        default: sym_p1 = CTRL_TOKEN_11;
      endcase
      cnt_nxt = '0;
    end else if ((cnt == disparity_t'(0)) || (n1_p1 == n0_p1)) begin
      sym_p1  = {~q_m_p1[8], q_m_p1[8], q_m_p1[8] ? q_m_p1[7:0] : ~q_m_p1[7:0]};
      cnt_nxt = q_m_p1[8] ? (cnt + diff_p1) : (cnt - diff_p1);
    end else if (((cnt > disparity_t'(0)) && (n1_p1 > n0_p1)) ||
                 ((cnt < disparity_t'(0)) && (n0_p1 > n1_p1))) begin
      // Invert the byte to pull the tally back toward zero.
      sym_p1  = {1'b1, q_m_p1[8], ~q_m_p1[7:0]};
      cnt_nxt = cnt - diff_p1 + (q_m_p1[8] ? disparity_t'(2) : disparity_t'(0));
    end else begin
      sym_p1  = {1'b0, q_m_p1[8], q_m_p1[7:0]};
      cnt_nxt = cnt + diff_p1 - (q_m_p1[8] ? disparity_t'(0) : disparity_t'(2));
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      tmds_out <= '0;
      cnt      <= '0;
    end else begin
      tmds_out <= sym_p1;
      cnt      <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_tmds_encoder.sv
module tb_tmds_encoder;

`ifdef TMDS_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam int RN = 10000;

  logic       clk_in = 1'b0;
  logic       rst_in;
  logic [7:0] data_in;
  logic [1:0] control_in;
  logic       ve_in;
  logic [9:0] tmds_out;

  tmds_encoder dut (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .data_in    (data_in),
    .control_in (control_in),
    .ve_in      (ve_in),
    .tmds_out   (tmds_out)
  );

  always #5 clk_in = ~clk_in;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       ve;
    logic [1:0] ctrl;
    logic [7:0] data;
    logic [9:0] exp;
  } vec_t;

  vec_t vecs[13];

  logic [9:0] rexp[RN];
  logic [7:0] rdat[RN];
  logic       rve[RN];
  logic [1:0] rctl[RN];
  int         mcnt;

  task automatic chk(input string name, input logic [9:0] act, input logic [9:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic drive(input logic ve, input logic [1:0] c, input logic [7:0] d);
    ve_in = ve;
    control_in = c;
    data_in = d;
  endtask

  // Independent reference: bit-serial transition minimization + balance rule.
  task automatic model_enc(input logic ve, input logic [1:0] c, input logic [7:0] d,
                           output logic [9:0] sym);
    int ones, n1, n0;
    logic xn;
    logic [7:0] qm;
    logic q8;
    if (!ve) begin
      case (c)
        2'b00: sym = 10'b1101010100;
        2'b01: sym = 10'b0010101011;
        2'b10: sym = 10'b0101010100;
        default: sym = 10'b1010101011;
      endcase
      mcnt = 0;
      return;
    end
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    xn = (ones > 4) || (ones == 4 && d[0] == 1'b0);
    qm[0] = d[0];
    for (int i = 1; i < 8; i++) qm[i] = xn ? (qm[i-1] ~^ d[i]) : (qm[i-1] ^ d[i]);
    q8 = !xn;
    n1 = 0;
    for (int i = 0; i < 8; i++) n1 += int'(qm[i]);
    n0 = 8 - n1;
    if (mcnt == 0 || n1 == n0) begin
      sym = {~q8, q8, (q8 ? qm : ~qm)};
      mcnt += q8 ? (n1 - n0) : (n0 - n1);
    end else if ((mcnt > 0 && n1 > n0) || (mcnt < 0 && n0 > n1)) begin
      sym = {1'b1, q8, ~qm};
      mcnt += 2 * int'(q8) + (n0 - n1);
    end else begin
      sym = {1'b0, q8, qm};
      mcnt += -2 * int'(!q8) + (n1 - n0);
    end
  endtask

  function automatic logic [7:0] decode(input logic [9:0] s);
    logic [7:0] v, d;
    v = s[9] ? ~s[7:0] : s[7:0];
    d[0] = v[0];
    for (int i = 1; i < 8; i++) d[i] = s[8] ? (v[i] ^ v[i-1]) : ~(v[i] ^ v[i-1]);
    return d;
  endfunction

  initial begin
    vecs[0]  = '{1'b0, 2'b00, 8'h00, 10'b1101010100};
    vecs[1]  = '{1'b0, 2'b01, 8'h00, 10'b0010101011};
    vecs[2]  = '{1'b0, 2'b10, 8'h00, 10'b0101010100};
    vecs[3]  = '{1'b0, 2'b11, 8'h00, 10'b1010101011};
    vecs[4]  = '{1'b1, 2'b00, 8'h00, 10'b0100000000};  // cnt -> -8
    vecs[5]  = '{1'b1, 2'b00, 8'h00, 10'b1111111111};  // cnt -> +2
    vecs[6]  = '{1'b1, 2'b00, 8'h00, 10'b0100000000};  // cnt -> -6
    vecs[7]  = '{1'b0, 2'b00, 8'h00, 10'b1101010100};  // tally cleared
    vecs[8]  = '{1'b1, 2'b00, 8'h00, 10'b0100000000};  // restarted at 0
    vecs[9]  = '{1'b0, 2'b00, 8'h00, 10'b1101010100};
    vecs[10] = '{1'b1, 2'b00, 8'hFF, 10'b1000000000};  // cnt -> -8
    vecs[11] = '{1'b1, 2'b00, 8'hFF, 10'b0011111111};  // cnt -> -2
    vecs[12] = '{1'b0, 2'b00, 8'h00, 10'b1101010100};

    // Power-on reset
    rst_in = 1'b1;
    drive(1'b0, 2'b00, 8'h00);
    repeat (2) @(posedge clk_in);
    #1;
    chk("reset_value", tmds_out, 10'b0);
    rst_in = 1'b0;

    // Directed table
    for (int i = 0; i < 13 + LAT - 1; i++) begin
      if (i < 13) drive(vecs[i].ve, vecs[i].ctrl, vecs[i].data);
      else        drive(1'b0, 2'b00, 8'h00);
      @(posedge clk_in);
      #1;
      if (i - (LAT - 1) >= 0) chk($sformatf("vec%0d", i - (LAT - 1)), tmds_out, vecs[i - (LAT - 1)].exp);
    end

    // Mid-stream reset: build a nonzero tally, reset asynchronously, check restart
    drive(1'b1, 2'b00, 8'h00);
    repeat (LAT + 1) @(posedge clk_in);
    #3;
    rst_in = 1'b1;
    #1;
    chk("async_reset_mid", tmds_out, 10'b0);
    @(negedge clk_in);
    rst_in = 1'b0;
    drive(1'b1, 2'b00, 8'h00);
    repeat (LAT) @(posedge clk_in);
    #1;
    chk("after_reset_zero", tmds_out, 10'b0100000000);

    // Reset release into control 00
    rst_in = 1'b1;
    #2;
    rst_in = 1'b0;
    drive(1'b0, 2'b00, 8'h00);
    repeat (LAT) @(posedge clk_in);
    #1;
    chk("reset_then_ctrl00", tmds_out, 10'b1101010100);

    // Random line with occasional blanking, against the reference model
    mcnt = 0;
    for (int i = 0; i < RN; i++) begin
      rdat[i] = 8'($urandom_range(0, 255));
      rctl[i] = 2'($urandom_range(0, 3));
      rve[i]  = (i == 0) ? 1'b0 : ($urandom_range(0, 63) != 0);
      model_enc(rve[i], rctl[i], rdat[i], rexp[i]);
      if (mcnt > 10 || mcnt < -10) begin
        errors++;
        $display("FAIL model_cnt_bound: got %0d required within +-10", mcnt);
      end
    end
    for (int i = 0; i < RN + LAT - 1; i++) begin
      if (i < RN) drive(rve[i], rctl[i], rdat[i]);
      else        drive(1'b0, 2'b00, 8'h00);
      @(posedge clk_in);
      #1;
      if (i - (LAT - 1) >= 0) begin
        int j;
        j = i - (LAT - 1);
        chk($sformatf("rand%0d", j), tmds_out, rexp[j]);
        if (rve[j]) chk($sformatf("decode%0d", j), {2'b00, decode(tmds_out)}, {2'b00, rdat[j]});
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tmds_encoder.md
# tmds_encoder

Registered DVI/HDMI TMDS channel encoder that turns one 8-bit video byte or 2-bit control symbol per pixel clock into a 10-bit DC-balanced TMDS symbol. It sequences the transition-minimization stage (`tm_choice`) and keeps a running-disparity tally across the active line. During blanking it emits the fixed control tokens. One instance per colour channel sits between the video pipeline and the 10:1 serializer.

## Interface
- No parameters.
- `clk_in` input 1: pixel clock.
- `rst_in` input 1: asynchronous, active-high reset.
- `data_in` input 8: video byte, sampled when `ve_in`=1.
- `control_in` input 2: control bits {C1,C0}, sampled when `ve_in`=0.
- `ve_in` input 1: video enable; 1 selects the data path, 0 selects the control path.
- `tmds_out` output 10: encoded symbol, registered, bit 0 transmitted first.

## Operation
- Stage A is combinational: `q_m[8:0]` = `tm_choice(data_in)`.
- N1 = popcount(q_m[7:0]). N0 = 8 − N1.
- Disparity tally `cnt` is 5-bit signed and registered. Its algorithmic range is within ±10, so it does not wrap.
- Video path (`ve_in`=1):
  - Case 1, `cnt`==0 or N1==N0:
    - `tmds_out` = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]}.
    - `cnt` += q_m[8] ? (N1−N0) : (N0−N1).
  - Case 2, else if (`cnt`>0 and N1>N0) or (`cnt`<0 and N0>N1):
    - `tmds_out` = {1, q_m[8], ~q_m[7:0]}.
    - `cnt` += 2·q_m[8] + (N0−N1).
  - Case 3, otherwise:
    - `tmds_out` = {0, q_m[8], q_m[7:0]}.
    - `cnt` += −2·(~q_m[8]) + (N1−N0).
- Control path (`ve_in`=0):
  - `control_in` 00 → 10'b1101010100.
  - 01 → 10'b0010101011.
  - 10 → 10'b0101010100.
  - 11 → 10'b1010101011.
  - `cnt` ← 0 on every control cycle.
- The arithmetic is done in sign-extended 5-bit. N1 and N0 are 4-bit unsigned, zero-extended before subtraction.

## Timing
- Reset value while `rst_in`=1: `tmds_out`=10'b0 and `cnt`=0. Assertion clears them asynchronously, including mid-line.
- The first symbol after reset release uses `cnt`=0.
- Latency is 1 clock: inputs sampled at edge k appear on `tmds_out` after edge k.
- `cnt` is updated on the same edge as `tmds_out`, so the next symbol sees the new tally.
- Video→control transition: the control token is emitted next cycle and `cnt` clears on that edge.
- Control→video transition: the first video symbol uses `cnt`=0.
- No handshake. One symbol is produced every cycle unconditionally.

## Configuration
- Macro `TMDS_PIPE_EN`.
- Defined:
  - An extra register stage captures `q_m`, `ve_in` and `control_in` after `tm_choice`.
  - Latency is 2 clocks.
  - All stage registers reset to 0. The stage-1 `ve_in` resets to 0, so the first output after reset is the control token for 00.
- Undefined: single stage, latency 1, as above.
- The encoded output sequence is identical in both builds apart from the one-cycle shift.

## Structure
- Package `tmds_pkg` holds:
  - `CTRL_TOKEN_00`..`CTRL_TOKEN_11` (10-bit localparams).
  - `CNT_W`=5.
  - typedef `disparity_t` (logic signed [CNT_W-1:0]).
- Sub-module: one `tm_choice` instance for stage A. Popcount is a function in `tmds_pkg`.

## Test plan
- Reset: hold `rst_in`=1 mid-stream → `tmds_out`=0 immediately. After release with `ve_in`=0 and ctrl=00 → next symbol 10'b1101010100.
- Control sweep: `ve_in`=0, ctrl 00/01/10/11 on consecutive cycles → 1101010100, 0010101011, 0101010100, 1010101011, each one cycle later.
- Zero run: control, then `data_in`=8'h00 for three cycles → tmds 0100000000 (`cnt`=−8), then 1111111111 (`cnt`=+2), then 0100000000 (`cnt`=−6).
- 0xFF from zero: `cnt`=0, `data_in`=8'hFF → 1000000000 and `cnt`=−8.
- Blanking clears the tally: after the zero run (`cnt`=−6), one `ve_in`=0 cycle, then 8'h00 → 0100000000 again (`cnt` restarted at 0).
- Random line: 10k random bytes checked against a reference model, with `cnt` bounded in ±10. Every decoded symbol equals its input. Repeat with `TMDS_PIPE_EN` and the latency shifted by 1.
